chroma_downsample: RTL and testbench

CHROMA_DOWNSAMPLE -- requirements
Module: chroma_downsample

---
 rtl/chroma_downsample.sv | 155 +++++++++++++++
 tb/tb_chroma_downsample.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_downsample.sv
// 4:4:4 -> 4:2:2 chroma decimator: 11-tap halfband filter, one shared multiplier, three MAC cycles per output.
// First word valid 4 cycles after x[7]; EMIT holds all state until write_ready, in_ready is low outside IDLE/FILL.
module chroma_downsample #(
  parameter int WIDTH = 320
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        line_start,
  input  logic        in_valid,
  input  logic [7:0]  sample_in,
  output logic        in_ready,
  output logic        write_valid,
  output logic [15:0] write_data,
  input  logic        write_ready,
  output logic [15:0] word_count,
  output logic        line_done
);

  typedef enum logic [2:0] {IDLE, FILL, MAC1, MAC2, MAC3, FLUSH, EMIT} state_t;

  localparam logic [15:0] LAST_IN  = 16'(WIDTH - 1);
  localparam logic [15:0] LAST_POS = 16'(WIDTH + 3);

  state_t             state, state_nxt;
  logic [10:0][7:0]   t;
  logic [15:0]        n;      // index of the sample held in t[0], virtual past the line end
  logic signed [31:0] acc;
  logic [7:0]         hi_byte;

  logic [8:0]         tap_sum;
  logic [7:0]         coef;
  logic [16:0]        prod;
  logic signed [31:0] prod_s;
  logic signed [31:0] acc_fin;
  logic signed [31:0] acc_shr;
  logic [7:0]         res;
  logic               k_odd;
  logic               flushing;

  // n = 2k+5, so k is odd exactly when n mod 4 == 3
  assign k_odd    = n[1];
  assign flushing = (n >= LAST_IN);

  always_comb begin
    tap_sum = 9'(t[0]) + 9'(t[10]);
    coef    = 8'd21;
    case (state)
      MAC2: begin
        tap_sum = 9'(t[2]) + 9'(t[8]);
        coef    = 8'd52;
      end
      MAC3: begin
        tap_sum = 9'(t[4]) + 9'(t[6]);
        coef    = 8'd159;
      end
      default: ;
    endcase
    prod    = 17'(tap_sum) * 17'(coef);
    prod_s  = $signed({15'b0, prod});
    acc_fin = acc + prod_s;
    acc_shr = acc_fin >>> 9;
    if (acc_shr < 0)
      res = 8'd0;
    else if (acc_shr > 32'sd255)
      res = 8'hFF;
    else
      res = acc_shr[7:0];
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    write_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && line_start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && !n[0] && n >= 16'd4) state_nxt = MAC1;
      end
      MAC1: state_nxt = MAC2;
      MAC2: state_nxt = MAC3;
      MAC3: begin
        if (k_odd)         state_nxt = EMIT;
        else if (flushing) state_nxt = FLUSH;
        else               state_nxt = FILL;
      end
      FLUSH: begin
        if (!n[0]) state_nxt = MAC1;
      end
      EMIT: begin
        write_valid = 1'b1;
        if (write_ready) begin
          if (n == LAST_POS)  state_nxt = IDLE;
          else if (flushing)  state_nxt = FLUSH;
          else                state_nxt = FILL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      t          <= '0;
      n          <= '0;
      acc        <= '0;
      hi_byte    <= '0;
      write_data <= '0;
      word_count <= '0;
      line_done  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && line_start) begin
            t <= {11{sample_in}};
            n <= '0;
          end
        end
        FILL: begin
          if (in_valid) begin
            t <= {t[9:0], sample_in};
            n <= n + 16'd1;
          end
        end
        FLUSH: begin
          t <= {t[9:0], t[0]};
          n <= n + 16'd1;
        end
        MAC1: acc <= 32'sd256 + $signed({16'b0, t[5], 8'b0}) + prod_s;
        MAC2: acc <= acc - prod_s;
        MAC3: begin
          if (k_odd) write_data <= {hi_byte, res};
          else       hi_byte    <= res;
        end
        EMIT: begin
          if (write_ready) begin
            word_count <= word_count + 16'd1;
            if (n == LAST_POS) line_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chroma_downsample.sv
// Bench for chroma_downsample at WIDTH=16: directed and random lines scored against a
// formula-level filter model, with backpressure, latency, line_done and reset-recovery checks.
module tb_chroma_downsample;
  localparam int WIDTH = 16;

  logic        CLOCK_50_I = 1'b0;
  logic        reset;
  logic        line_start;
  logic        in_valid;
  logic [7:0]  sample_in;
  logic        in_ready;
  logic        write_valid;
  logic [15:0] write_data;
  logic        write_ready;
  logic [15:0] word_count;
  logic        line_done;

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  chroma_downsample #(.WIDTH(WIDTH)) dut (
    .CLOCK_50_I  (CLOCK_50_I),
    .reset       (reset),
    .line_start  (line_start),
    .in_valid    (in_valid),
    .sample_in   (sample_in),
    .in_ready    (in_ready),
    .write_valid (write_valid),
    .write_data  (write_data),
    .write_ready (write_ready),
    .word_count  (word_count),
    .line_done   (line_done)
  );

  int          tests = 0;
  int          fails = 0;
  int          line_buf [WIDTH];
  logic [15:0] exp_q [$];
  int          model_count = 0;
  int          ld_seen = 0;
  int          cyc = 0;
  int          first_rise = -1;
  int          t7_cyc = 0;
  int          bp_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int xs(input int i);
    int j;
    j = i;
    if (j < 0) j = 0;
    if (j > WIDTH - 1) j = WIDTH - 1;
    return line_buf[j];
  endfunction

  function automatic logic [7:0] ref_out(input int k);
    int a;
    a = 21 * (xs(2*k-5) + xs(2*k+5)) - 52 * (xs(2*k-3) + xs(2*k+3))
      + 159 * (xs(2*k-1) + xs(2*k+1)) + 256 * xs(2*k) + 256;
    a = a >>> 9;
    if (a < 0) return 8'd0;
    if (a > 255) return 8'd255;
    return a[7:0];
  endfunction

  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  initial begin
    write_ready = 1'b1;
    forever begin
      @(posedge CLOCK_50_I);
      #1;
      case (bp_mode)
        0:       write_ready = 1'b1;
        1:       write_ready = ($urandom_range(0, 2) != 0);
        default: write_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, line_done and first-rise tracking
  initial begin
    logic        prev_hold;
    logic        prev_wv;
    logic [15:0] prev_data;
    prev_hold = 1'b0;
    prev_wv   = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge CLOCK_50_I);
      if (prev_hold && !reset) begin
        check("stall_valid", write_valid, 1'b1);
        check("stall_data", write_data, prev_data);
      end
      if (write_valid && write_ready && !reset) begin
        check("word_expected", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) check("word_data", write_data, exp_q.pop_front());
        model_count++;
      end
      if (line_done) ld_seen++;
      if (write_valid && !prev_wv && first_rise < 0) first_rise = cyc;
      prev_wv   = write_valid;
      prev_hold = write_valid && !write_ready && !reset;
      prev_data = write_data;
    end
  end

  task automatic send_sample(input logic [7:0] s, input logic ls, output int xcyc);
    logic got;
    int   guard;
    in_valid   = 1'b1;
    sample_in  = s;
    line_start = ls;
    guard      = 0;
    do begin
      @(negedge CLOCK_50_I);
      got  = in_ready;
      xcyc = cyc;
      @(posedge CLOCK_50_I);
      #1;
      guard++;
    end while (!got && guard < 300);
    if (!got) check("in_ready_timeout", got, 1'b1);
    in_valid   = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic send_line(input bit gaps, input int mid_ls);
    int xc;
    for (int m = 0; m < WIDTH / 4; m++)
      exp_q.push_back({ref_out(2*m), ref_out(2*m+1)});
    first_rise = -1;
    for (int i = 0; i < WIDTH; i++) begin
      send_sample(line_buf[i][7:0], (i == 0) || (i == mid_ls), xc);
      if (i == 7) t7_cyc = xc;
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) begin
          @(posedge CLOCK_50_I);
          #1;
        end
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 600) begin
      @(posedge CLOCK_50_I);
      #1;
      guard++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge CLOCK_50_I);
    #1;
  endtask

  initial begin
    int ld0;
    int wc;
    int xc;
    int guard;
    reset      = 1'b1;
    in_valid   = 1'b0;
    line_start = 1'b0;
    sample_in  = '0;
    repeat (3) @(posedge CLOCK_50_I);
    #1;
    reset = 1'b0;
    model_count = 0;

    @(negedge CLOCK_50_I);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_write_valid", write_valid, 1'b0);
    check("rst_write_data", write_data, 16'h0000);
    check("rst_word_count", word_count, 16'h0000);
    check("rst_line_done", line_done, 1'b0);
    @(posedge CLOCK_50_I);
    #1;

    // Samples without line_start in IDLE are swallowed
    for (int i = 0; i < 3; i++) send_sample(8'hAA, 1'b0, xc);
    repeat (4) @(posedge CLOCK_50_I);
    #1;
    check("idle_discard_count", word_count, 16'h0000);

    // Constant 100 line, full throughput: latency and pulse count
    for (int i = 0; i < WIDTH; i++) line_buf[i] = 100;
    ld0 = ld_seen;
    send_line(1'b0, -1);
    wait_drain();
    check("latency_x7", first_rise - t7_cyc, 4);
    check("const_line_done", ld_seen - ld0, 1);
    check("const_word_count", word_count, 16'(model_count));

    // Single impulse at x[9]
    for (int i = 0; i < WIDTH; i++) line_buf[i] = (i == 9) ? 255 : 0;
    send_line(1'b0, -1);
    wait_drain();

    // Alternating 0 / 255
    for (int i = 0; i < WIDTH; i++) line_buf[i] = (i % 2) ? 255 : 0;
    send_line(1'b1, -1);
    wait_drain();

    // Upper clip around out[4]
    for (int i = 0; i < WIDTH; i++)
      line_buf[i] = (i == 3 || i == 7 || i == 8 || i == 9 || i == 13) ? 255 : 0;
    send_line(1'b0, -1);
    wait_drain();

    // Random lines with input gaps, random write_ready, and a stray mid-line line_start
    bp_mode = 1;
    ld0 = ld_seen;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < WIDTH; i++) line_buf[i] = int'($urandom_range(0, 255));
      send_line(1'b1, int'($urandom_range(1, WIDTH - 1)));
      wait_drain();
    end
    bp_mode = 0;
    repeat (2) @(posedge CLOCK_50_I);
    #1;
    check("rand_line_done", ld_seen - ld0, 6);
    check("rand_word_count", word_count, 16'(model_count));

    // Ten-cycle stall on the first word of a line
    for (int i = 0; i < WIDTH; i++) line_buf[i] = int'($urandom_range(0, 255));
    bp_mode = 2;
    wc = model_count;
    fork
      send_line(1'b0, -1);
      begin
        guard = 0;
        while (!write_valid && guard < 300) begin
          @(negedge CLOCK_50_I);
          guard++;
        end
        check("stall_reached", write_valid, 1'b1);
        repeat (10) @(negedge CLOCK_50_I);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_word_count", word_count, 16'(wc));
        bp_mode = 0;
        @(posedge CLOCK_50_I);
        @(posedge CLOCK_50_I);
        @(negedge CLOCK_50_I);
        check("stall_release_count", word_count, 16'(wc + 1));
      end
    join
    wait_drain();
    check("stall_total_count", word_count, 16'(wc + 4));

    // Reset in MAC2 of a partial line, then a clean constant-50 line
    for (int i = 0; i < 6; i++) send_sample(8'(i * 40 + 7), (i == 0), xc);
    @(posedge CLOCK_50_I);
    #1;
    reset = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_count = 0;
    @(negedge CLOCK_50_I);
    check("mid_rst_word_count", word_count, 16'h0000);
    check("mid_rst_write_valid", write_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge CLOCK_50_I);
    #1;
    for (int i = 0; i < WIDTH; i++) line_buf[i] = 50;
    send_line(1'b0, -1);
    wait_drain();
    check("post_rst_word_count", word_count, 16'd4);
    check("post_rst_model_count", model_count, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
